// File: rtl/nt_rare_trigger_monitor.sv
// rtl/nt_rare_trigger_monitor.sv - rare-trigger monitor on net I2574: window ones-density, run length, sticky alarm
// Optional NT_MON_HISTORY_EN adds the hist port: a snapshot of the sample history taken on alarm entry.
module nt_rare_trigger_monitor #(
  parameter int WIN_LOG2 = 4,
  parameter int RARE_MAX = 2,
  parameter int RUN_MAX  = 3,
  parameter int CNT_W    = 8
) (
  input  logic                I1470_clk,
  input  logic                I1477_rst,
  input  logic                I2574,
  input  logic                smp_en,
  input  logic                arm,
  input  logic                ack,
  input  logic                clr,
  output logic                alarm,
  output logic [1:0]          alarm_code,
  output logic [WIN_LOG2:0]   ones_cnt,
  output logic [CNT_W-1:0]    evt_cnt,
  output logic [1:0]          state_o
`ifdef NT_MON_HISTORY_EN
  ,
  output logic [2**WIN_LOG2-1:0] hist
`endif
);

  localparam logic [1:0]          ST_DISARMED = 2'b00;
  localparam logic [1:0]          ST_ARMED    = 2'b01;
  localparam logic [1:0]          ST_ALARM    = 2'b10;
  localparam logic [WIN_LOG2-1:0] IDX_MAX     = '1;
  localparam logic [WIN_LOG2:0]   RARE_TOP    = (WIN_LOG2+1)'(RARE_MAX);
  localparam logic [3:0]          RUN_TOP     = 4'(RUN_MAX);
  localparam logic [3:0]          RUN_PRE     = 4'(RUN_MAX - 1);
  localparam logic [CNT_W-1:0]    EVT_MAX     = '1;

  logic [WIN_LOG2-1:0] win_idx;
  logic [WIN_LOG2:0]   win_ones;
  logic [3:0]          run_len;
  logic [1:0]          state;

  logic                win_close;
  logic [WIN_LOG2:0]   total;
  logic                rare_trig;
  logic                run_trig;
  logic [1:0]          trig;
  logic                any_trig;

  assign win_close = smp_en && (win_idx == IDX_MAX);
  assign total     = win_ones + {{WIN_LOG2{1'b0}}, I2574};
  assign rare_trig = win_close && (total != '0) && (total <= RARE_TOP);
  // Only the step into RUN_MAX fires, so a long run reports once.
  assign run_trig  = smp_en && I2574 && (run_len == RUN_PRE);
  assign trig      = {run_trig, rare_trig};
  assign any_trig  = |trig;
  assign state_o   = state;

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      win_idx  <= '0;
      win_ones <= '0;
      run_len  <= '0;
      ones_cnt <= '0;
    end else if (clr) begin
      win_idx  <= '0;
      win_ones <= '0;
      run_len  <= '0;
      ones_cnt <= '0;
    end else if (smp_en) begin
      win_idx <= win_idx + 1'b1;
      if (win_close) begin
        ones_cnt <= total;
        win_ones <= '0;
      end else begin
        win_ones <= total;
      end
      if (!I2574)
        run_len <= '0;
      else if (run_len != RUN_TOP)
        run_len <= run_len + 1'b1;
    end
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      state      <= ST_DISARMED;
      alarm      <= 1'b0;
      alarm_code <= 2'b00;
      evt_cnt    <= '0;
    end else if (clr) begin
      state      <= ST_DISARMED;
      alarm      <= 1'b0;
      alarm_code <= 2'b00;
      evt_cnt    <= '0;
    end else begin
      if (any_trig && (state != ST_DISARMED) && (evt_cnt != EVT_MAX))
        evt_cnt <= evt_cnt + 1'b1;
      case (state)
        ST_DISARMED: begin
          if (arm)
            state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (any_trig) begin
            state      <= ST_ALARM;
            alarm      <= 1'b1;
            alarm_code <= trig;
          end else if (!arm) begin
            state <= ST_DISARMED;
          end
        end
        ST_ALARM: begin
          // An ack that collides with a fresh trigger keeps the alarm, reporting only the new cause.
          if (ack && any_trig) begin
            alarm_code <= trig;
          end else if (ack) begin
            state      <= arm ? ST_ARMED : ST_DISARMED;
            alarm      <= 1'b0;
            alarm_code <= 2'b00;
          end else begin
            alarm_code <= alarm_code | trig;
          end
        end
        default: begin
          state      <= ST_DISARMED;
          alarm      <= 1'b0;
          alarm_code <= 2'b00;
        end
      endcase
    end
  end

`ifdef NT_MON_HISTORY_EN
  logic [2**WIN_LOG2-1:0] hist_sr;
  logic [2**WIN_LOG2-1:0] hist_next;
  logic                   hist_capture;
  logic                   hist_release;

  assign hist_next    = smp_en ? {hist_sr[2**WIN_LOG2-2:0], I2574} : hist_sr;
  assign hist_capture = ((state == ST_ARMED) && any_trig) || ((state == ST_ALARM) && ack && any_trig);
  assign hist_release = (state == ST_ALARM) && ack && !any_trig;

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      hist_sr <= '0;
      hist    <= '0;
    end else if (clr) begin
      hist_sr <= '0;
      hist    <= '0;
    end else begin
      hist_sr <= hist_next;
      if (hist_capture)
        hist <= hist_next;
      else if (hist_release)
        hist <= '0;
    end
  end
`endif

endmodule

// File: doc/nt_rare_trigger_monitor.md
# nt_rare_trigger_monitor

Sequential monitor that sits directly downstream of an Nt-node subcircuit and consumes its single-bit output net, I2574. It samples the net on a strobe, measures the ones-density per fixed window and the length of consecutive-one runs, and raises a sticky alarm with a cause code when activity looks like a rare trojan trigger. An acknowledge handshake clears the alarm, and a saturating counter records how many trigger events have occurred.

## Interface
- WIN_LOG2, 4: window length is 2^WIN_LOG2 samples.
- RARE_MAX, 2: a closed window whose ones count lies in 1..RARE_MAX is a rare-activity trigger.
- RUN_MAX, 3: RUN_MAX consecutive sampled ones is a run trigger; range 2..15.
- CNT_W, 8: width of the event counter.
- I1470_clk  in  1  sole clock; rising edge.
- I1477_rst  in  1  asynchronous, active-high reset.
- I2574  in  1  monitored net from the upstream subcircuit.
- smp_en  in  1  sample strobe; I2574 is sampled on cycles where this is 1.
- arm  in  1  level; enables trigger reporting.
- ack  in  1  one-cycle pulse; acknowledges the alarm.
- clr  in  1  synchronous clear of all state.
- alarm  out  1  sticky alarm.
- alarm_code  out  2  bit0 = rare-window cause, bit1 = run cause.
- ones_cnt  out  WIN_LOG2+1  ones count of the last closed window.
- evt_cnt  out  CNT_W  saturating trigger-event count.
- state_o  out  2  FSM state: 00 DISARMED, 01 ARMED, 10 ALARM.

## Operation
- Sample path (active on every smp_en cycle, in any state):
  - win_idx counts 0..2^WIN_LOG2-1 and wraps.
  - win_ones accumulates the sampled ones.
  - On the sample with win_idx = max, the window closes: total = win_ones + sample.
  - At close: ones_cnt <= total and win_ones <= 0. Nothing carries into the next window.
- Run tracking:
  - run_len increments on a sampled 1, saturating at RUN_MAX; a sampled 0 clears it.
  - The run trigger fires only on the transition of run_len from RUN_MAX-1 to RUN_MAX, so there is one trigger per run.
- Rare trigger: fires at window close when 1 ≤ total ≤ RARE_MAX. A total of 0 or a full window never triggers.
- FSM:
  - DISARMED: triggers are ignored. Moves to ARMED when arm = 1.
  - ARMED: any trigger moves to ALARM, sets alarm = 1 and alarm_code = trigger bits. arm = 0 moves to DISARMED.
  - ALARM: further triggers OR into alarm_code.
    - ack with no trigger in the same cycle: go to ARMED (or DISARMED if arm = 0), alarm = 0, code = 00.
    - ack with a trigger in the same cycle: stay in ALARM, code = new trigger bits only.
    - arm = 0 does not leave ALARM; only ack does.
- evt_cnt increments by 1 on each cycle in which at least one trigger fires while not DISARMED. It saturates at 2^CNT_W-1.
- smp_en = 0: sample, window and run state are frozen; ack, arm and clr still act.
- Priority: I1477_rst > clr > ack/trigger > arm.

## Timing
- Reset values (async assert, also applied by clr):
  - Outputs: alarm = 0, alarm_code = 00, ones_cnt = 0, evt_cnt = 0, state_o = DISARMED.
  - Internal: win_idx = 0, win_ones = 0, run_len = 0.
- Latency: the trigger is derived from the sample in cycle N. alarm, alarm_code, evt_cnt and ones_cnt are registered and visible in cycle N+1.
- Simultaneous rare and run trigger on the same sample: code bits OR together and evt_cnt increments by 1.
- Reset mid-window discards the partial window. Reset deassertion is synchronous to I1470_clk; the first sample is taken on the first edge after deassertion.
- Every output is a flop output; no combinational path from any input to any output.

## Configuration
- NT_MON_HISTORY_EN:
  - Defined: adds output hist [2^WIN_LOG2-1:0], a shift register of the sampled I2574 values with the newest value in bit 0.
  - hist is captured into a hold register on entry to ALARM and holds until ack. Reset value is 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use default parameters and arm = 1 unless stated.
- Reset mid-run: assert I1477_rst asynchronously mid-window with alarm = 1 -> all outputs read 0 immediately; the next window starts at win_idx = 0.
- Rare window: 16 samples with ones at idx 3 and 9 -> one cycle after idx 15, ones_cnt = 2, alarm = 1, alarm_code = 01, evt_cnt = 1.
- Run trigger: samples 1,1,1,1,0,1,1,1 -> alarm_code = 10; evt_cnt = 2, from the 3rd one and again from the 8th sample, with ack between them.
- Ack collision: ack on the same cycle a new run trigger fires -> state stays ALARM, code = 10, evt_cnt +1.
- Disarmed and frozen:
  - arm = 0 with a window of 1 one -> ones_cnt = 1, alarm = 0, evt_cnt = 0.
  - smp_en = 0 for 5 cycles -> win_idx unchanged.
- Saturation and clr: force 300 triggers -> evt_cnt holds at 255; clr pulse -> all outputs 0 on the next cycle.
